// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter
//   Round-robin arbiter for the shared MESI snoop bus (Address_Com /
//   Data_Bus_Com) between the per-core L1 cache controllers. The owner
//   keeps the bus until it drops its request; the bus then stays closed
//   until every other core has finished snooping the transaction.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   Bus_req      per-core bus request (level, held for the transaction)
//   Snoop_done   per-core snoop-complete flag (level)
//   Bus_grant    registered one-hot grant (zero outside GRANT)
//   Grant_id     registered index of the current or last owner
//   Bus_busy     high in GRANT and WAIT_SNOOP
//   Timeout_err  one-cycle pulse when a grant is revoked by timeout
//
// Build option:
//   BUS_TIMEOUT_EN  when defined, an owner is limited to MAX_HOLD
//                   consecutive grant cycles; otherwise Timeout_err is 0
//                   and a grant is held for as long as it is requested.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | no owner; arbitrate pending requests from rr_q
// GRANT      | Grant_id owns the bus until its request drops
// WAIT_SNOOP | bus closed until all non-owner cores report snoop done

module snoop_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] Bus_req,
  input  logic [NUM_REQ-1:0] Snoop_done,
  output logic [NUM_REQ-1:0] Bus_grant,
  output logic [IDW-1:0]     Grant_id,
  output logic               Bus_busy,
  output logic               Timeout_err
);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("snoop_bus_arbiter: NUM_REQ must be at least 2");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("snoop_bus_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    WAIT_SNOOP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [IDW-1:0]     id_d;
  logic [IDW-1:0]     sel;
  logic [IDW-1:0]     cand;
  logic               found;
  logic [NUM_REQ-1:0] owner_mask;
  int                 idx;

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_d;
`endif

  // First requester at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDW'(idx);
      if (!found && Bus_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // The owner's own snoop flag is irrelevant to closing the transaction.
  assign owner_mask = NUM_REQ'(1) << Grant_id;

  always_comb begin
    state_d = state_q;
    grant_d = Bus_grant;
    id_d    = Grant_id;
    rr_d    = rr_q;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << sel;
          id_d    = sel;
          rr_d    = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      GRANT: begin
        if (!Bus_req[Grant_id]) begin
          state_d = WAIT_SNOOP;
          grant_d = '0;
        end
`ifdef BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
          // This edge ends the MAX_HOLD-th grant cycle.
          state_d = WAIT_SNOOP;
          grant_d = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      WAIT_SNOOP: begin
        grant_d = '0;
        if (&(Snoop_done | owner_mask)) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      Bus_grant <= '0;
      Grant_id  <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      Bus_grant <= grant_d;
      Grant_id  <= id_d;
      rr_q      <= rr_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      Timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      Timeout_err <= tmo_d;
    end
  end
`else
  assign Timeout_err = 1'b0;
`endif

  assign Bus_busy = (state_q == GRANT) || (state_q == WAIT_SNOOP);

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
module tb_snoop_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Bus_req = '0;
  logic [3:0] Snoop_done = '0;
  logic [3:0] Bus_grant;
  logic [1:0] Grant_id;
  logic       Bus_busy;
  logic       Timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];

  snoop_bus_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .Bus_req     (Bus_req),
    .Snoop_done  (Snoop_done),
    .Bus_grant   (Bus_grant),
    .Grant_id    (Grant_id),
    .Bus_busy    (Bus_busy),
    .Timeout_err (Timeout_err)
  );

  always #5 clk = ~clk;

  // One clock: drive inputs on the falling edge, queue the outputs expected
  // after the next rising edge, then compare just after that edge.
  task automatic cyc(input logic [3:0] req, input logic [3:0] snp,
                     input logic [3:0] eg, input logic [1:0] eid,
                     input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    Bus_req    = req;
    Snoop_done = snp;
    exp_q.push_back({eg, eid, eb, et});
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty: observed size %0d expected >0", exp_q.size());
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (Bus_grant === e.grant) else begin
        errors++;
        $error("FAIL grant @%0t: observed %b expected %b", $time, Bus_grant, e.grant);
      end
      checks++;
      assert (Grant_id === e.id) else begin
        errors++;
        $error("FAIL grant_id @%0t: observed %0d expected %0d", $time, Grant_id, e.id);
      end
      checks++;
      assert (Bus_busy === e.busy) else begin
        errors++;
        $error("FAIL busy @%0t: observed %b expected %b", $time, Bus_busy, e.busy);
      end
      checks++;
      assert (Timeout_err === e.tmo) else begin
        errors++;
        $error("FAIL timeout_err @%0t: observed %b expected %b", $time, Timeout_err, e.tmo);
      end
    end
  endtask

  initial begin
    int         order[5];
    int         k;
    logic [3:0] oh;
    order = '{0, 1, 2, 3, 0};

    // Reset state.
    rst = 1'b1;
    cyc(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b1111, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // All four request; each owner holds 3 grant cycles, drops for one cycle.
    for (int n = 0; n < 5; n++) begin
      k  = order[n];
      oh = 4'b0001 << k;
      cyc(4'b1111, 4'b1111, oh, 2'(k), 1'b1, 1'b0);
      repeat (2) cyc(4'b1111, 4'b1111, oh, 2'(k), 1'b1, 1'b0);
      cyc(4'b1111 & ~oh, 4'b1111, 4'b0000, 2'(k), 1'b1, 1'b0);
      cyc(4'b1111, 4'b1111, 4'b0000, 2'(k), 1'b0, 1'b0);
    end

    // rr_ptr = 1 now: 4'b1001 goes to core 3 first, then core 0.
    cyc(4'b1001, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc(4'b0001, 4'b1111, 4'b0000, 2'd3, 1'b1, 1'b0);
    cyc(4'b0001, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc(4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 1: WAIT_SNOOP holds until the last non-owner bit (3) rises;
    // the owner's own bit is low at that point and must be ignored.
    cyc(4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0011, 4'b0000, 2'd1, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0011, 4'b0000, 2'd1, 1'b1, 1'b0);
    cyc(4'b0100, 4'b0111, 4'b0000, 2'd1, 1'b1, 1'b0);
    cyc(4'b0100, 4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0);
    cyc(4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);

    // Reset in the middle of core 2's grant, then rr_ptr restarts at 0.
    cyc(4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(4'b0101, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
    cyc(4'b0100, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
    cyc(4'b0100, 4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0);

    // Core 3 holds its request.
    cyc(4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
`ifdef BUS_TIMEOUT_EN
    repeat (15) cyc(4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    cyc(4'b1000, 4'b1111, 4'b0000, 2'd3, 1'b1, 1'b1);
    cyc(4'b1000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);
    cyc(4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
`else
    repeat (99) cyc(4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
`endif
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0);

    // One-cycle request pulse: one grant cycle, one WAIT_SNOOP, then IDLE.
    cyc(4'b0001, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
    cyc(4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
